// File: rtl/io_handshake_sequencer_if.sv
// Handshake bundle between the decoder/buttons side and the I/O stall sequencer.
// The master drives the instruction id and raw buttons; the slave returns enable and status.
interface io_handshake_sequencer_if #(
    parameter int unsigned ID_WIDTH = 7
) ();
    logic [ID_WIDTH-1:0] id;
    logic                confirmation;
    logic                continue_button;
    logic                enable;
    logic                is_input;
    logic                is_output;
    logic                io_waiting;
    logic                halted;

    modport master (
        output id,
        output confirmation,
        output continue_button,
        input  enable,
        input  is_input,
        input  is_output,
        input  io_waiting,
        input  halted
    );

    modport slave (
        input  id,
        input  confirmation,
        input  continue_button,
        output enable,
        output is_input,
        output is_output,
        output io_waiting,
        output halted
    );
endinterface

// File: rtl/io_handshake_sequencer.sv
// Stall controller: commits each OUTPUT/PAUSE/INPUT once per debounced button press
// and latches HALT until reset.
module io_handshake_sequencer #(
    parameter int unsigned ID_WIDTH        = 7,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned OUTPUT_ID       = 69,
    parameter int unsigned PAUSE_ID        = 70,
    parameter int unsigned INPUT_ID        = 71,
    parameter int unsigned HALT_ID         = 75
) (
    input logic                      clock,
    input logic                      reset,
    io_handshake_sequencer_if.slave  bus
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES);

    localparam logic [ID_WIDTH-1:0] OutputId = ID_WIDTH'(OUTPUT_ID);
    localparam logic [ID_WIDTH-1:0] PauseId  = ID_WIDTH'(PAUSE_ID);
    localparam logic [ID_WIDTH-1:0] InputId  = ID_WIDTH'(INPUT_ID);
    localparam logic [ID_WIDTH-1:0] HaltId   = ID_WIDTH'(HALT_ID);

    typedef enum logic [1:0] {StRun, StWaitPress, StCommit, StHalted} state_e;
    typedef enum logic [1:0] {ClsNone, ClsOutput, ClsPause, ClsInput} io_class_e;

    function automatic logic class_is_input(io_class_e c);
        return (c == ClsInput) || (c == ClsPause);
    endfunction

    function automatic logic class_is_output(io_class_e c);
        return (c == ClsOutput) || (c == ClsPause);
    endfunction

    // Button channels: bit 0 = confirmation, bit 1 = continue_button.
    logic [1:0]      raw_buttons;
    logic [1:0]      sync1_q, sync1_d;
    logic [1:0]      sync2_q, sync2_d;
    logic [1:0]      deb_q, deb_d;
    logic [1:0]      deb_prev_q, deb_prev_d;
    logic [CntW-1:0] cnt_q [2];
    logic [CntW-1:0] cnt_d [2];
    logic [1:0]      press;

    state_e    state_q, state_d;
    io_class_e cls_q, cls_d;
    io_class_e id_cls;
    logic      id_is_halt;
    logic      sel_press;

    logic enable;
    logic is_input;
    logic is_output;

    assign raw_buttons = {bus.continue_button, bus.confirmation};

    always_comb begin
        sync1_d    = raw_buttons;
        sync2_d    = sync1_q;
        deb_prev_d = deb_q;
        deb_d      = deb_q;
        for (int ch = 0; ch < 2; ch++) begin
            cnt_d[ch] = '0;
            // Level flips once the synchronised value has disagreed for the full window.
            if (sync2_q[ch] != deb_q[ch]) begin
                if (cnt_q[ch] == CntMax) begin
                    deb_d[ch] = sync2_q[ch];
                end else begin
                    cnt_d[ch] = cnt_q[ch] + 1'b1;
                end
            end
        end
    end

    assign press = deb_q & ~deb_prev_q;

    always_comb begin
        id_cls = ClsNone;
        if (bus.id == OutputId) begin
            id_cls = ClsOutput;
        end else if (bus.id == PauseId) begin
            id_cls = ClsPause;
        end else if (bus.id == InputId) begin
            id_cls = ClsInput;
        end
        id_is_halt = (bus.id == HaltId);
    end

    assign sel_press = (cls_q == ClsPause) ? press[1] : press[0];

    always_comb begin
        state_d   = state_q;
        cls_d     = cls_q;
        enable    = 1'b0;
        is_input  = 1'b0;
        is_output = 1'b0;
        unique case (state_q)
            StRun: begin
                enable    = (id_cls == ClsNone) && !id_is_halt;
                is_input  = class_is_input(id_cls);
                is_output = class_is_output(id_cls);
                // A press arriving in this cycle is dropped; the wait needs a fresh edge.
                if (id_cls != ClsNone) begin
                    state_d = StWaitPress;
                    cls_d   = id_cls;
                end else if (id_is_halt) begin
                    state_d = StHalted;
                end
            end
            StWaitPress: begin
                is_input  = class_is_input(cls_q);
                is_output = class_is_output(cls_q);
                if (sel_press) begin
                    state_d = StCommit;
                end
            end
            StCommit: begin
                enable    = 1'b1;
                is_input  = class_is_input(cls_q);
                is_output = class_is_output(cls_q);
                state_d   = StRun;
            end
            StHalted: begin
                state_d = StHalted;
            end
            default: begin
                state_d = StRun;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int ch = 0; ch < 2; ch++) begin
                cnt_q[ch] <= '0;
            end
            state_q    <= StRun;
            cls_q      <= ClsNone;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            for (int ch = 0; ch < 2; ch++) begin
                cnt_q[ch] <= cnt_d[ch];
            end
            state_q    <= state_d;
            cls_q      <= cls_d;
        end
    end

    assign bus.enable     = enable;
    assign bus.is_input   = is_input;
    assign bus.is_output  = is_output;
    assign bus.io_waiting = (state_q == StWaitPress);
    assign bus.halted     = (state_q == StHalted);

endmodule

// File: tb/tb_io_handshake_sequencer.sv
// Randomised and directed bench for io_handshake_sequencer against a behavioural model
// built from button histories and an abstract pending-instruction record.
module tb_io_handshake_sequencer;

    localparam int unsigned Deb     = 4;
    localparam int unsigned HistLen = Deb + 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    io_handshake_sequencer_if #(.ID_WIDTH(7)) bus ();

    io_handshake_sequencer #(
        .ID_WIDTH        (7),
        .DEBOUNCE_CYCLES (Deb),
        .OUTPUT_ID       (69),
        .PAUSE_ID        (70),
        .INPUT_ID        (71),
        .HALT_ID         (75)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Model: 0 running, 1 waiting for press, 2 committing, 3 halted.
    int               m_mode;
    int               m_cls;
    logic             m_deb [2];
    logic             m_deb_prev [2];
    logic [HistLen-1:0] m_hist [2];  // bit k = raw sample k cycles ago

    logic obs_en;
    int   cur_id;
    int   next_id;
    int   commits;
    int   commit_cyc;
    int   t_idx;

    function automatic bit is_io(int v);
        return (v == 69) || (v == 70) || (v == 71);
    endfunction

    task automatic model_reset();
        m_mode = 0;
        m_cls  = 0;
        for (int ch = 0; ch < 2; ch++) begin
            m_deb[ch]      = 1'b0;
            m_deb_prev[ch] = 1'b0;
            m_hist[ch]     = '0;
        end
    endtask

    task automatic step(input int id_v, input bit conf_v, input bit cont_v);
        logic e_en, e_in, e_out, e_wait, e_halt;
        bit   p [2];
        bit   raw [2];
        logic [HistLen-3:0] win;
        bus.id              = 7'(id_v);
        bus.confirmation    = conf_v;
        bus.continue_button = cont_v;
        #2;
        p[0] = m_deb[0] && !m_deb_prev[0];
        p[1] = m_deb[1] && !m_deb_prev[1];
        e_en = 1'b0; e_in = 1'b0; e_out = 1'b0; e_wait = 1'b0; e_halt = 1'b0;
        case (m_mode)
            0: begin
                e_en  = !(is_io(id_v) || id_v == 75);
                e_in  = (id_v == 71) || (id_v == 70);
                e_out = (id_v == 69) || (id_v == 70);
            end
            1: begin
                e_in   = (m_cls != 69);
                e_out  = (m_cls != 71);
                e_wait = 1'b1;
            end
            2: begin
                e_en  = 1'b1;
                e_in  = (m_cls != 69);
                e_out = (m_cls != 71);
            end
            default: e_halt = 1'b1;
        endcase
        check_eq("enable", bus.enable, e_en);
        check_eq("is_input", bus.is_input, e_in);
        check_eq("is_output", bus.is_output, e_out);
        check_eq("io_waiting", bus.io_waiting, e_wait);
        check_eq("halted", bus.halted, e_halt);
        obs_en = bus.enable;

        case (m_mode)
            0: begin
                if (is_io(id_v)) begin
                    m_mode = 1;
                    m_cls  = id_v;
                end else if (id_v == 75) begin
                    m_mode = 3;
                end
            end
            1: if ((m_cls == 70) ? p[1] : p[0]) m_mode = 2;
            2: m_mode = 0;
            default: m_mode = 3;
        endcase

        // Debounced level follows the raw level once it has held for Deb+1 samples
        // seen through the two-cycle synchroniser delay.
        raw[0] = conf_v;
        raw[1] = cont_v;
        for (int ch = 0; ch < 2; ch++) begin
            m_deb_prev[ch] = m_deb[ch];
            m_hist[ch]     = {m_hist[ch][HistLen-2:0], raw[ch]};
            win            = m_hist[ch][HistLen-1:2];
            if (&win) m_deb[ch] = 1'b1;
            else if (win == '0) m_deb[ch] = 1'b0;
        end
        @(posedge clock);
        #1;
    endtask

    task automatic tick(input bit conf_v, input bit cont_v);
        int id_used;
        id_used = cur_id;
        step(id_used, conf_v, cont_v);
        if (obs_en) begin
            if (is_io(id_used)) begin
                commits++;
                commit_cyc = t_idx;
            end
            cur_id = next_id;
        end
        t_idx++;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        check_eq("rst_io_waiting", bus.io_waiting, 1'b0);
        check_eq("rst_halted", bus.halted, 1'b0);
        model_reset();
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    task automatic settle();
        cur_id  = 5;
        next_id = 5;
        for (int i = 0; i < 10; i++) tick(1'b0, 1'b0);
    endtask

    function automatic int rand_id();
        int r;
        r = int'($urandom_range(0, 31));
        if (r < 12) return int'($urandom_range(0, 68));
        if (r < 28) return 69 + int'($urandom_range(0, 2));
        if (r < 30) begin
            r = int'($urandom_range(72, 127));
            return (r == 75) ? 76 : r;
        end
        return 75;
    endfunction

    initial begin
        bit conf_r;
        bit cont_r;
        int halt_len;
        bus.id              = 7'd5;
        bus.confirmation    = 1'b0;
        bus.continue_button = 1'b0;
        cur_id  = 5;
        next_id = 5;
        commits = 0;
        commit_cyc = -1;
        t_idx   = 0;
        obs_en  = 1'b0;
        model_reset();
        @(posedge clock);
        #1;
        do_reset();

        // Plain instructions advance every cycle.
        settle();

        // OUTPUT with confirmation rising at cycle 10 and then held.
        cur_id = 69; next_id = 69; commits = 0; commit_cyc = -1; t_idx = 0;
        for (int c = 0; c < 31; c++) tick(c >= 10, 1'b0);
        check_eq("out_commit_cycle", commit_cyc, 18);
        check_eq("out_commit_count", commits, 1);
        for (int c = 0; c < 8; c++) tick(1'b0, 1'b0);
        check_eq("out_held_no_commit", commits, 1);
        next_id = 5;
        for (int c = 0; c < 12; c++) tick(1'b1, 1'b0);
        check_eq("out_repress_commit", commits, 2);
        settle();

        // INPUT with a 3-cycle glitch on confirmation.
        cur_id = 71; next_id = 5; commits = 0;
        for (int c = 0; c < 20; c++) tick((c >= 2) && (c < 5), 1'b0);
        check_eq("glitch_no_commit", commits, 0);
        check_eq("glitch_is_input", bus.is_input, 1'b1);
        for (int c = 0; c < 12; c++) tick(1'b1, 1'b0);
        check_eq("input_commit", commits, 1);
        settle();

        // PAUSE ignores confirmation, commits on continue_button.
        cur_id = 70; next_id = 5; commits = 0;
        for (int c = 0; c < 12; c++) tick(1'b1, 1'b0);
        for (int c = 0; c < 5; c++) tick(1'b0, 1'b0);
        check_eq("pause_wrong_channel", commits, 0);
        for (int c = 0; c < 12; c++) tick(1'b0, 1'b1);
        check_eq("pause_commit", commits, 1);
        settle();

        // HALT is sticky against both buttons.
        cur_id = 75; next_id = 5;
        for (int c = 0; c < 20; c++) tick(c >= 3, c >= 3);
        check_eq("halt_latched", bus.halted, 1'b1);
        check_eq("halt_enable", bus.enable, 1'b0);
        do_reset();
        settle();

        // Reset while waiting for INPUT: the stall re-arms and needs a new press.
        cur_id = 71; next_id = 5; commits = 0;
        for (int c = 0; c < 5; c++) tick(1'b0, 1'b0);
        check_eq("wait_before_reset", bus.io_waiting, 1'b1);
        do_reset();
        for (int c = 0; c < 4; c++) tick(1'b0, 1'b0);
        check_eq("rewait_after_reset", bus.io_waiting, 1'b1);
        check_eq("rewait_no_commit", commits, 0);
        for (int c = 0; c < 12; c++) tick(1'b1, 1'b0);
        check_eq("rewait_commit", commits, 1);
        settle();

        // Random instruction stream with bouncing buttons and occasional resets.
        conf_r   = 1'b0;
        cont_r   = 1'b0;
        halt_len = 0;
        for (int i = 0; i < 4000; i++) begin
            if (($urandom_range(0, 399) == 0) || (halt_len > 20)) begin
                do_reset();
                halt_len = 0;
                if (cur_id == 75) cur_id = 5;
            end
            next_id = rand_id();
            if ($urandom_range(0, 4) == 0) conf_r = !conf_r;
            if ($urandom_range(0, 4) == 0) cont_r = !cont_r;
            tick(conf_r, cont_r);
            halt_len = (m_mode == 3) ? halt_len + 1 : 0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
